dmem_bus_bridge: RTL and testbench

//   Sits directly downstream of the load/store unit. Accepts one word-aligned request
//   {a, we, be, d} on the decoupled mem_req channel and runs it as one classic

---
 rtl/dmem_bus_bridge_pkg.sv | 12 +
 rtl/dmem_bus_bridge_watchdog.sv | 20 ++
 rtl/dmem_bus_bridge.sv | 81 ++++++++
 tb/tb_dmem_bus_bridge.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared types for the load/store-to-bus bridge
package dmem_bus_bridge_pkg;
    typedef logic [31:0] addr;
    typedef logic [31:0] mtrans;
    typedef struct packed {
        addr        a;
        logic       we;
        logic [3:0] be;
        mtrans      d;
    } mem_req_t;
    typedef enum logic [1:0] {BR_IDLE, BR_BUS, BR_RESP} bridge_state_e;
endpackage

// File: rtl/dmem_bus_bridge_watchdog.sv
// bus_watchdog: counts cycles of one bus transfer and flags when the wait limit is reached
module bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst || clear)
            cnt <= '0;
        else if (run)
            cnt <= cnt + 1'b1;
    end
    assign expired = run && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: runs one load/store request as a single Wishbone-style bus cycle
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic [31:0] mem_req_a,
    input  logic        mem_req_we,
    input  logic [3:0]  mem_req_be,
    input  logic [31:0] mem_req_d,
    output logic        mem_resp_valid,
    input  logic        mem_resp_ready,
    output logic [31:0] mem_resp_data,
    output logic        resp_err,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_dat_w,
    input  logic [31:0] bus_dat_r,
    input  logic        bus_ack,
    input  logic        bus_err
);
    bridge_state_e state;
    mem_req_t      req, req_q;
    logic          in_bus, expired, done;

    assign req    = '{a: mem_req_a, we: mem_req_we, be: mem_req_be, d: mem_req_d};
    assign in_bus = state == BR_BUS;
    assign done   = in_bus && (bus_err || bus_ack || expired);

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .run    (in_bus),
        .clear  (done),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= BR_IDLE;
            req_q         <= '0;
            mem_resp_data <= '0;
            resp_err      <= 1'b0;
        end else begin
            case (state)
                BR_IDLE: if (mem_req_valid) begin
                    req_q         <= req;
                    state         <= (req.be == 4'b0) ? BR_RESP : BR_BUS;
                    mem_resp_data <= '0;
                    resp_err      <= req.be == 4'b0;
                end
                // error beats ack; without either, we only get here on expiry
                BR_BUS: if (done) begin
                    state         <= BR_RESP;
                    resp_err      <= bus_err || !bus_ack;
                    mem_resp_data <= (bus_err || !bus_ack || req_q.we) ? '0 : bus_dat_r;
                end
                BR_RESP: if (mem_resp_ready) state <= BR_IDLE;
                default: state <= BR_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_ready  = state == BR_IDLE;
        mem_resp_valid = state == BR_RESP;
        bus_cyc        = in_bus;
        bus_stb        = in_bus;
        bus_we         = req_q.we;
        bus_adr        = req_q.a & ~32'h3;
        bus_sel        = req_q.be;
        bus_dat_w      = req_q.d;
    end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: scoreboard bench; driver plays the bus slave, monitor checks responses
module tb_dmem_bus_bridge;
    localparam int TO = 8;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_req_valid = 1'b0, mem_req_ready;
    logic [31:0] mem_req_a = '0, mem_req_d = '0;
    logic        mem_req_we = 1'b0;
    logic [3:0]  mem_req_be = '0;
    logic        mem_resp_valid, mem_resp_ready = 1'b1;
    logic [31:0] mem_resp_data;
    logic        resp_err, bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_adr, bus_dat_w;
    logic [3:0]  bus_sel;
    logic [31:0] bus_dat_r = '0;
    logic        bus_ack = 1'b0, bus_err = 1'b0;

    exp_t exp_q[$];
    int   total = 0, passed = 0, bp_hold = 0;
    bit   bp_rand = 0;

    dmem_bus_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_a(mem_req_a), .mem_req_we(mem_req_we), .mem_req_be(mem_req_be), .mem_req_d(mem_req_d),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data), .resp_err(resp_err),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
        .bus_sel(bus_sel), .bus_dat_w(bus_dat_w), .bus_dat_r(bus_dat_r),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want)
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        else
            passed++;
    endtask

    // kind: 0 ack, 1 err, 2 ack+err; w >= TO means the slave never answers
    task automatic txn(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] d,
                       input int w, input int kind, input logic [31:0] rd);
        int   n;
        bit   ok;
        exp_t e;
        e.e = (be == 4'b0) || (w >= TO) || (kind != 0);
        e.d = (e.e || we) ? 32'h0 : rd;
        n = 0;
        while (!mem_req_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mem_req_ready) begin
            check("req_ready_wait", 0, 1);
            return;
        end
        exp_q.push_back(e);
        mem_req_valid = 1'b1;
        mem_req_a = a; mem_req_we = we; mem_req_be = be; mem_req_d = d;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        mem_req_a = $urandom; mem_req_we = 1'($urandom); mem_req_be = 4'($urandom); mem_req_d = $urandom;
        n = 0;
        ok = 1;
        while (bus_cyc && n < TO + 4) begin
            ok = ok && bus_stb && bus_adr == (a & ~32'h3) && bus_sel == be && bus_we == we && bus_dat_w == d;
            if (n == w) begin
                bus_ack = kind != 1;
                bus_err = kind != 0;
                bus_dat_r = rd;
            end else
                bus_dat_r = $urandom;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_err = 1'b0;
            n++;
        end
        check("bus_fields", 32'(ok), 1);
        check("cyc_cycles", n, be == 4'b0 ? 0 : (w < TO ? w + 1 : TO));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bp_hold > 0) begin
                mem_resp_ready = 1'b0;
                if (mem_resp_valid) bp_hold--;
            end else
                mem_resp_ready = bp_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        exp_t        e;
        bit          have_prev = 0, chk_rdy = 0;
        logic [31:0] prev_d = '0;
        logic        prev_e = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_rdy) begin
                check("ready_after_resp", 32'(mem_req_ready), 1);
                chk_rdy = 0;
            end
            if (mem_resp_valid) begin
                check("req_ready_low", 32'(mem_req_ready), 0);
                if (have_prev) begin
                    check("hold_data", mem_resp_data, prev_d);
                    check("hold_err", 32'(resp_err), 32'(prev_e));
                end
                if (mem_resp_ready) begin
                    if (exp_q.size() == 0)
                        check("unexpected_resp", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("resp_data", mem_resp_data, e.d);
                        check("resp_err", 32'(resp_err), 32'(e.e));
                    end
                    have_prev = 0;
                    chk_rdy = 1;
                end else begin
                    have_prev = 1;
                    prev_d = mem_resp_data;
                    prev_e = resp_err;
                end
            end else
                have_prev = 0;
        end
    end

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 32'(bus_cyc), 0);
        check("rst_resp_valid", 32'(mem_resp_valid), 0);
        check("rst_resp_err", 32'(resp_err), 0);
        check("rst_resp_data", mem_resp_data, 0);
        check("rst_req_ready", 32'(mem_req_ready), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        txn(32'h100, 1'b0, 4'hF, 32'h0, 3, 0, 32'hDEADBEEF);
        txn(32'h204, 1'b1, 4'hC, 32'h12340000, 0, 0, 32'h55AA55AA);
        txn(32'h300, 1'b0, 4'hF, 32'h0, 100, 0, 32'h0);
        txn(32'h307, 1'b0, 4'h3, 32'h0, 2, 0, 32'hCAFEF00D);
        txn(32'h40C, 1'b0, 4'hF, 32'h0, 1, 2, 32'h11111111);
        txn(32'h410, 1'b0, 4'h0, 32'h0, 0, 0, 32'h22222222);
        bp_hold = 5;
        txn(32'h500, 1'b0, 4'hF, 32'h0, 1, 0, 32'hA5A5A5A5);
        drain();

        // abort a cycle in flight with reset
        mem_req_valid = 1'b1; mem_req_a = 32'h600; mem_req_we = 1'b0; mem_req_be = 4'hF;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        check("bus_before_rst", 32'(bus_cyc), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("cyc_after_rst", 32'(bus_cyc), 0);
        check("resp_after_rst", 32'(mem_resp_valid), 0);
        rst = 1'b1;
        repeat (3) begin
            bus_ack = 1'b1;
            bus_dat_r = $urandom;
            @(posedge clk); #1;
            check("stray_ack_resp", 32'(mem_resp_valid), 0);
            check("stray_ack_cyc", 32'(bus_cyc), 0);
        end
        bus_ack = 1'b0;

        bp_rand = 1;
        repeat (40) begin
            r = $urandom_range(0, 9);
            txn($urandom, 1'($urandom), ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                $urandom, $urandom_range(0, 9), r < 6 ? 0 : (r < 8 ? 1 : 2), $urandom);
        end
        bp_rand = 0;
        drain();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
